// File: rtl/seq_stage_if.sv
// seq_stage_if: signal bundle between the SEQ stage controller and its environment.
//   host-driven : start, step_mode, icode, instr_valid, imem_error, dmem_ready, dmem_error
//   ctrl-driven : fetch_en, decode_en, execute_en, mem_en, wb_en, pc_en,
//                 stat, busy, state, cycle_count, instr_count
// master = host/datapath side (drives start and the stage status inputs),
// slave  = the controller (consumes them and produces the enables and status).
interface seq_stage_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic             step_mode;
  logic [3:0]       icode;
  logic             instr_valid;
  logic             imem_error;
  logic             dmem_ready;
  logic             dmem_error;
  logic             fetch_en;
  logic             decode_en;
  logic             execute_en;
  logic             mem_en;
  logic             wb_en;
  logic             pc_en;
  logic [2:0]       stat;
  logic             busy;
  logic [2:0]       state;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output start, step_mode, icode, instr_valid, imem_error, dmem_ready, dmem_error,
    input  fetch_en, decode_en, execute_en, mem_en, wb_en, pc_en,
           stat, busy, state, cycle_count, instr_count
  );

  modport slave (
    input  start, step_mode, icode, instr_valid, imem_error, dmem_ready, dmem_error,
    output fetch_en, decode_en, execute_en, mem_en, wb_en, pc_en,
           stat, busy, state, cycle_count, instr_count
  );
endinterface

// File: rtl/seq_stage_controller.sv
// seq_stage_controller: multi-cycle sequencer for the Y86-64 SEQ datapath.
// Walks one instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/PCUPD,
// skipping stages the icode does not need, waiting on the data-memory
// handshake (with a timeout), tracking stat and keeping saturating
// cycle / retired-instruction counters.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset, overrides everything
//   bus   - seq_stage_if.slave (control inputs, stage enables, status, counters)
module seq_stage_controller #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  seq_stage_if.slave  bus
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEMORY  = 3'd4,
    S_WB      = 3'd5,
    S_PCUPD   = 3'd6,
    S_HALTED  = 3'd7
  } state_e;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  state_e            state_q, state_d;
  logic [2:0]        stat_q, stat_d;
  logic [3:0]        icode_q, icode_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [CNT_W-1:0]  ins_q, ins_d;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      stat_q  <= STAT_AOK;
      icode_q <= '0;
      wait_q  <= '0;
      cyc_q   <= '0;
      ins_q   <= '0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      icode_q <= icode_d;
      wait_q  <= wait_d;
      cyc_q   <= cyc_d;
      ins_q   <= ins_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    icode_d = icode_q;
    wait_d  = wait_q;
    cyc_d   = cyc_q;
    ins_d   = ins_q;

    // Cycle counter runs in every working state and saturates at all-ones
    if (state_q != S_IDLE && state_q != S_HALTED && cyc_q != '1)
      cyc_d = cyc_q + 1'b1;

    case (state_q)
      S_IDLE: if (bus.start) state_d = S_FETCH;
      S_FETCH: begin
        icode_d = bus.icode;
        // Fault priority: address fault, then illegal instruction, then halt
        if (bus.imem_error) begin
          state_d = S_HALTED;
          stat_d  = STAT_ADR;
        end else if (!bus.instr_valid) begin
          state_d = S_HALTED;
          stat_d  = STAT_INS;
        end else if (bus.icode == 4'h0) begin
          state_d = S_HALTED;
          stat_d  = STAT_HLT;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        wait_d = '0;  // fresh wait budget for the upcoming MEMORY visit
        case (icode_q)
          4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11: state_d = S_MEMORY;
          4'd2, 4'd3, 4'd6:                     state_d = S_WB;
          default:                              state_d = S_PCUPD;
        endcase
      end
      S_MEMORY: begin
        // A ready response on the last allowed cycle still completes normally
        if (bus.dmem_ready) begin
          if (bus.dmem_error) begin
            state_d = S_HALTED;
            stat_d  = STAT_ADR;
          end else begin
            state_d = (icode_q == 4'd4) ? S_PCUPD : S_WB;
          end
        end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
          state_d = S_HALTED;
          stat_d  = STAT_ADR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB: state_d = S_PCUPD;
      S_PCUPD: begin
        if (ins_q != '1) ins_d = ins_q + 1'b1;
        state_d = bus.step_mode ? S_IDLE : S_FETCH;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    bus.fetch_en   = 1'b0;
    bus.decode_en  = 1'b0;
    bus.execute_en = 1'b0;
    bus.mem_en     = 1'b0;
    bus.wb_en      = 1'b0;
    bus.pc_en      = 1'b0;
    case (state_q)
      S_FETCH:   bus.fetch_en   = 1'b1;
      S_DECODE:  bus.decode_en  = 1'b1;
      S_EXECUTE: bus.execute_en = 1'b1;
      S_MEMORY:  bus.mem_en     = 1'b1;
      S_WB:      bus.wb_en      = 1'b1;
      S_PCUPD:   bus.pc_en      = 1'b1;
      default:   ;
    endcase
    bus.busy        = (state_q != S_IDLE) && (state_q != S_HALTED);
    bus.state       = state_q;
    bus.stat        = stat_q;
    bus.cycle_count = cyc_q;
    bus.instr_count = ins_q;
  end

endmodule

// File: tb/tb_seq_stage_controller.sv
module tb_seq_stage_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seq_stage_if #(.CNT_W(32)) bus ();

  seq_stage_controller #(.CNT_W(32), .MEM_TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] icode;
    bit         valid;
    bit         ierr;
    int         wait_n;   // MEMORY cycles before dmem_ready; large = never
    bit         derr;
    int         lat;      // expected busy cycles
    int         mcyc;     // expected mem_en cycles
    int         stat;
    int         fstate;   // expected terminal state
    int         icnt;     // expected instr_count
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  vec_t e;

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;
  int bcnt = 0;
  int mcnt = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: counts busy / mem_en cycles, compares when the DUT settles
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (bus.busy) begin
        bcnt++;
        if (bus.mem_en) mcnt++;
        chk("onehot_en", $countones({bus.fetch_en, bus.decode_en, bus.execute_en,
                                     bus.mem_en, bus.wb_en, bus.pc_en}), 1);
      end else if (bcnt > 0) begin
        if (exp_q.size() == 0) begin
          chk("sb_empty", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("latency",     bcnt, e.lat);
          chk("mem_cycles",  mcnt, e.mcyc);
          chk("stat",        bus.stat, e.stat);
          chk("final_state", bus.state, e.fstate);
          chk("instr_count", bus.instr_count, e.icnt);
          chk("cycle_count", bus.cycle_count, e.lat);
        end
        bcnt = 0;
        mcnt = 0;
      end
    end else begin
      bcnt = 0;
      mcnt = 0;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.start = 1'b0;
    bus.dmem_ready = 1'b0;
    bus.dmem_error = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int mc;
    bit done;
    do_reset();
    bus.icode = v.icode;
    bus.instr_valid = v.valid;
    bus.imem_error = v.ierr;
    bus.dmem_error = v.derr;
    bus.step_mode = 1'b1;
    exp_q.push_back(v);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    mc = 0;
    done = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      if (bus.mem_en) begin
        bus.dmem_ready = (mc == v.wait_n);
        mc++;
      end else begin
        bus.dmem_ready = 1'b0;
      end
      @(negedge clk);
      if (bus.state == 3'd0 || bus.state == 3'd7) done = 1;
    end
    bus.dmem_ready = 1'b0;
    if (!done) chk("vec_timeout", 0, 1);
  endtask

  int exp_st[6] = '{1, 2, 3, 5, 6, 1};
  bit pc_seen;
  bit hit;

  initial begin
    bus.start = 0; bus.step_mode = 0; bus.icode = 0; bus.instr_valid = 1;
    bus.imem_error = 0; bus.dmem_ready = 0; bus.dmem_error = 0;

    //            icode  v  ie wait derr lat mc st fs ic
    vecs.push_back('{4'd1,  1, 0, 0,   0, 4, 0, 1, 0, 1});
    vecs.push_back('{4'd7,  1, 0, 0,   0, 4, 0, 1, 0, 1});
    vecs.push_back('{4'd2,  1, 0, 0,   0, 5, 0, 1, 0, 1});
    vecs.push_back('{4'd3,  1, 0, 0,   0, 5, 0, 1, 0, 1});
    vecs.push_back('{4'd6,  1, 0, 0,   0, 5, 0, 1, 0, 1});
    vecs.push_back('{4'd4,  1, 0, 0,   0, 5, 1, 1, 0, 1});
    vecs.push_back('{4'd4,  1, 0, 2,   0, 7, 3, 1, 0, 1});
    vecs.push_back('{4'd5,  1, 0, 0,   0, 6, 1, 1, 0, 1});
    vecs.push_back('{4'd5,  1, 0, 3,   0, 9, 4, 1, 0, 1});
    vecs.push_back('{4'd8,  1, 0, 2,   0, 8, 3, 1, 0, 1});
    vecs.push_back('{4'd9,  1, 0, 0,   0, 6, 1, 1, 0, 1});
    vecs.push_back('{4'd11, 1, 0, 1,   0, 7, 2, 1, 0, 1});
    vecs.push_back('{4'd10, 1, 0, 999, 0, 7, 4, 3, 7, 0});
    vecs.push_back('{4'd10, 1, 0, 3,   0, 9, 4, 1, 0, 1});
    vecs.push_back('{4'd10, 1, 0, 0,   1, 4, 1, 3, 7, 0});
    vecs.push_back('{4'd0,  1, 0, 0,   0, 1, 0, 2, 7, 0});
    vecs.push_back('{4'd6,  0, 0, 0,   0, 1, 0, 4, 7, 0});
    vecs.push_back('{4'd6,  0, 1, 0,   0, 1, 0, 3, 7, 0});
    vecs.push_back('{4'd0,  1, 1, 0,   0, 1, 0, 3, 7, 0});

    // Reset state
    do_reset();
    chk("rst_state", bus.state, 0);
    chk("rst_stat", bus.stat, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_en", {bus.fetch_en, bus.decode_en, bus.execute_en, bus.mem_en, bus.wb_en, bus.pc_en}, 0);
    chk("rst_cyc", bus.cycle_count, 0);
    chk("rst_ins", bus.instr_count, 0);

    // Table-driven run through the scoreboard
    mon_en = 1;
    foreach (vecs[i]) run_vec(vecs[i]);
    @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    mon_en = 0;

    // Free-running single instruction: F,D,E,WB,PCUPD then FETCH again
    do_reset();
    bus.step_mode = 0; bus.icode = 4'd6; bus.instr_valid = 1; bus.imem_error = 0;
    bus.start = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.start = 0;
      chk($sformatf("run_state_c%0d", i + 1), bus.state, exp_st[i]);
      if (i == 4) chk("run_pc_en", bus.pc_en, 1);
    end
    chk("run_ins", bus.instr_count, 1);
    chk("run_cyc", bus.cycle_count, 5);

    // Halt then start is ignored
    do_reset();
    bus.icode = 4'd0; bus.step_mode = 0;
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    @(negedge clk);
    chk("hlt_state", bus.state, 7);
    chk("hlt_stat", bus.stat, 2);
    chk("hlt_busy", bus.busy, 0);
    bus.start = 1;
    @(negedge clk);
    @(negedge clk);
    bus.start = 0;
    chk("hlt_start_ign", bus.state, 7);
    chk("hlt_ins", bus.instr_count, 0);

    // Step mode: two instructions via two start pulses
    do_reset();
    bus.icode = 4'd1; bus.step_mode = 1;
    for (int k = 0; k < 2; k++) begin
      bus.start = 1;
      @(negedge clk);
      bus.start = 0;
      hit = 0;
      for (int c = 0; c < 10 && !hit; c++) begin
        @(negedge clk);
        if (bus.state == 3'd0) hit = 1;
      end
      chk($sformatf("step_idle_%0d", k), hit, 1);
      chk($sformatf("step_ins_%0d", k), bus.instr_count, k + 1);
    end
    chk("step_cyc", bus.cycle_count, 8);

    // Reset asserted while waiting in MEMORY
    do_reset();
    bus.icode = 4'd5; bus.step_mode = 0; bus.dmem_ready = 0;
    pc_seen = 0;
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    hit = 0;
    for (int c = 0; c < 10 && !hit; c++) begin
      if (bus.pc_en) pc_seen = 1;
      if (bus.state == 3'd4) hit = 1;
      else @(negedge clk);
    end
    chk("mrst_reached_mem", hit, 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    if (bus.pc_en) pc_seen = 1;
    chk("mrst_state", bus.state, 0);
    chk("mrst_stat", bus.stat, 1);
    chk("mrst_cyc", bus.cycle_count, 0);
    chk("mrst_ins", bus.instr_count, 0);
    chk("mrst_mem_en", bus.mem_en, 0);
    chk("mrst_no_pc", pc_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
